lab3_cache_refill_collector: RTL and testbench
==============================================

Name: lab3_cache_refill_collector

Overview:
- Sits between the memory response port and the cache datapath refill path, in the M0 stage.
- Collects the 16 word-sized read responses of one line refill into a 512-bit line, placing each word by its opaque field. Responses may return in any order.
- Presents the finished line to the data-array write port and gives an early-restart pulse when the requested (critical) word arrives.
- Also counts writeback acknowledgements and signals when a 16-word writeback has fully drained.

Parameters:
- NWORDS, 16, words per cache line
- WORD_BITS, 32, bits per word
- OFF_BITS, 4, bits of word offset (log2 NWORDS)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start_val  in  1  control requests a new refill
- start_rdy  out  1  collector is idle and accepts a refill request
- start_crit_off  in  OFF_BITS  word offset of the critical word for this refill
- resp_val  in  1  memory response valid
- resp_rdy  out  1  collector accepts a memory response
- resp_msg  in  47  mem_resp_4B_t {type_, opaque, test, len, data}
- line_val  out  1  assembled line is valid
- line_rdy  in  1  datapath consumes the line (data array write happens this cycle)
- line_data  out  NWORDS*WORD_BITS  assembled line; word i occupies bits [32i+31:32i]
- crit_val  out  1  one-cycle pulse: critical word has arrived
- crit_data  out  WORD_BITS  critical word, held until the next refill
- wb_done  out  1  one-cycle pulse: 16th write ack received
- err  out  1  sticky protocol error flag

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; word-valid mask = 0; write-ack counter = 0.
  - All outputs low/zero, except start_rdy = 1 and resp_rdy = 1.
  - line_data and crit_data are reset to 0.
  - Reset asserted mid-fill abandons the fill; no line_val is produced.
- States:
  - IDLE: start_rdy = 1, resp_rdy = 1.
    - On start_val: latch crit_off, clear the mask, go to FILL.
  - FILL: start_rdy = 0, resp_rdy = 1.
    - Read response (type_ = 0) accepted on resp_val & resp_rdy: write data into word opaque[OFF_BITS-1:0] and set that mask bit.
    - When the accepted beat completes the mask (all 16 bits), go to FULL the next cycle.
  - FULL: line_val = 1, resp_rdy = 0, start_rdy = 0.
    - On line_rdy: go to IDLE and clear the mask.
- Latency:
  - line_val rises the cycle after the 16th read beat is accepted.
  - crit_val pulses the cycle after the critical word is accepted. crit_data is registered at the same edge.
- Write acks (type_ = 1):
  - Accepted whenever resp_rdy = 1, in any state other than FULL; they never touch the line.
  - Each ack increments a 5-bit counter.
  - On the 16th ack: wb_done pulses the next cycle and the counter wraps to 0.
- Error conditions (err set and held until reset; the offending beat is dropped, state unchanged):
  - read response in IDLE;
  - read response whose word-valid bit is already set;
  - type_ other than 0 or 1;
  - len ≠ 0.
- Simultaneous events:
  - The final read beat and a write ack cannot arrive in the same cycle (one response port).
  - start_val in FILL or FULL is ignored, since start_rdy = 0.
  - line_rdy outside FULL is ignored.
- Mask widths:
  - The mask is NWORDS bits.
  - "Full" means every mask bit equals 1, including the beat being accepted this cycle.

Decomposition:
- Shared package (lab3_cache_pkg):
  - MEM_TYPE_READ = 0, MEM_TYPE_WRITE = 1
  - CACHE_LINE_WORDS = 16
  - CACHE_LINE_BITS = 512
  - collector state enum {IDLE, FILL, FULL}
- mem_resp_4B_t stays in vc/mem-msgs.v.
- One natural sub-module: lab3_cache_word_slot_bank. It holds the NWORDS write-enabled word registers plus the valid mask, with per-word write enable and clear-all.
- FSM, write-ack counter and error logic stay in the top module.

Test Plan:
- In-order fill: start (crit_off = 0), then read beats opaque 0..15 with data 0x100 + i.
  - line_val rises the cycle after beat 15; word i = 0x100 + i.
  - crit_val pulses after beat 0 with crit_data = 0x100.
- Reverse-order fill with crit_off = 5: beats opaque 15..0.
  - crit_val pulses exactly once, after opaque 5; crit_data = 0x105.
  - Line is correct; resp_rdy = 0 while line_val is held for 3 cycles with line_rdy = 0, then start_rdy returns to 1.
- Writeback drain: 16 write-ack beats interleaved during a fill.
  - wb_done pulses once after the 16th ack; the line still completes correctly; counter returns to 0.
- Errors: duplicate opaque 3 during a fill, then a read beat in IDLE.
  - err = 1 after the first error and stays 1; word 3 keeps its first value; line_val still requires the remaining 15 unique beats.
- Reset mid-operation: assert reset after 7 beats.
  - Immediately (no clock edge): line_val = 0, start_rdy = 1, err = 0.
  - A new fill afterwards completes normally with no stale mask bits.
- Back-to-back refills: start_val asserted the cycle after the line_rdy handshake.
  - Accepted in IDLE; the second line is assembled with no data carry-over.

Source files
------------

// File: rtl/lab3_cache_pkg.sv
// Shared definitions for the cache refill path.
// Holds the memory message type codes, cache line geometry, the refill
// collector state encoding and a field view of the 47-bit 4-byte memory
// response {type_, opaque, test, len, data}.
package lab3_cache_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    localparam int CACHE_LINE_WORDS = 16;
    localparam int CACHE_LINE_BITS  = 512;
    localparam int MEM_RESP_BITS    = 47;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } collector_state_e;

    // Field view of a 4-byte memory response, MSB first.
    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_view_t;

    // A response is well formed only when it is a full-word read or write ack.
    function automatic logic resp_format_ok(input mem_resp_view_t resp);
        return (resp.len == 2'd0) &&
               ((resp.type_ == MEM_TYPE_READ) || (resp.type_ == MEM_TYPE_WRITE));
    endfunction

endpackage

// File: rtl/lab3_cache_word_slot_bank.sv
// Word slot bank for one cache line being refilled.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   i_we         - write word i_widx with i_wdata and mark it valid
//   i_widx       - word offset to write
//   i_wdata      - word data
//   i_clr        - clear the whole valid mask (data words are kept)
//   o_mask       - per-word valid mask
//   o_line       - assembled line, word i at bits [WORD_BITS*i +: WORD_BITS]
module lab3_cache_word_slot_bank #(
    parameter int NWORDS    = 16,
    parameter int WORD_BITS = 32,
    parameter int OFF_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_we,
    input  logic [OFF_BITS-1:0]         i_widx,
    input  logic [WORD_BITS-1:0]        i_wdata,
    input  logic                        i_clr,
    output logic [NWORDS-1:0]           o_mask,
    output logic [NWORDS*WORD_BITS-1:0] o_line
);

    logic [NWORDS-1:0]           r_mask;
    logic [NWORDS*WORD_BITS-1:0] r_line;

    // Valid mask: clear-all wins, otherwise a write marks its slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (i_clr) begin
            r_mask <= '0;
        end else if (i_we) begin
            r_mask[i_widx] <= 1'b1;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Word storage: each slot is overwritten only by its own write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_line <= '0;
        end else if (i_we) begin
            r_line[int'(i_widx)*WORD_BITS +: WORD_BITS] <= i_wdata;
        end else begin
            r_line <= r_line;
        end
    end

    assign o_mask = r_mask;
    assign o_line = r_line;

endmodule

// File: rtl/lab3_cache_refill_collector.sv
// Cache refill collector: gathers the 16 read responses of a line refill
// (any order, placed by opaque) into one line, pulses early restart on the
// critical word, and counts writeback acks.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   start_val/start_rdy        - refill request handshake
//   start_crit_off             - critical word offset of the refill
//   resp_val/resp_rdy/resp_msg - memory response port
//   line_val/line_rdy          - finished line handshake to the data array
//   line_data                  - assembled line
//   crit_val, crit_data        - critical word pulse and held data
//   wb_done                    - pulse after the 16th write ack
//   err                        - sticky protocol error
module lab3_cache_refill_collector
    import lab3_cache_pkg::*;
#(
    parameter int NWORDS    = 16,
    parameter int WORD_BITS = 32,
    parameter int OFF_BITS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_val,
    output logic                        start_rdy,
    input  logic [OFF_BITS-1:0]         start_crit_off,
    input  logic                        resp_val,
    output logic                        resp_rdy,
    input  logic [MEM_RESP_BITS-1:0]    resp_msg,
    output logic                        line_val,
    input  logic                        line_rdy,
    output logic [NWORDS*WORD_BITS-1:0] line_data,
    output logic                        crit_val,
    output logic [WORD_BITS-1:0]        crit_data,
    output logic                        wb_done,
    output logic                        err
);

    localparam logic [4:0] WB_LAST = 5'd15;

    collector_state_e     r_state;
    logic                 r_start_rdy;
    logic                 r_resp_rdy;
    logic                 r_line_val;
    logic                 r_crit_val;
    logic                 r_wb_done;
    logic                 r_err;
    logic [OFF_BITS-1:0]  r_crit_off;
    logic [WORD_BITS-1:0] r_crit_data;
    logic [4:0]           r_wb_cnt;

    mem_resp_view_t       w_resp;
    logic [OFF_BITS-1:0]  w_off;
    logic [NWORDS-1:0]    w_mask;
    logic [NWORDS-1:0]    w_off_onehot;
    logic [NWORDS-1:0]    w_mask_after;
    logic                 w_fire;
    logic                 w_fmt_ok;
    logic                 w_is_read;
    logic                 w_is_ack;
    logic                 w_dup;
    logic                 w_rd_ok;
    logic                 w_err_beat;
    logic                 w_completes;
    logic                 w_start;
    logic                 w_handoff;
    logic                 w_clr;
    logic                 w_crit_hit;
    logic                 w_unused_bits;

    assign w_resp        = mem_resp_view_t'(resp_msg);
    assign w_off         = w_resp.opaque[OFF_BITS-1:0];
    assign w_unused_bits = ^{w_resp.test, w_resp.opaque[7:OFF_BITS]};

    assign w_fire       = resp_val & r_resp_rdy;
    assign w_fmt_ok     = resp_format_ok(w_resp);
    assign w_is_read    = w_fire & w_fmt_ok & (w_resp.type_ == MEM_TYPE_READ);
    assign w_is_ack     = w_fire & w_fmt_ok & (w_resp.type_ == MEM_TYPE_WRITE);
    assign w_off_onehot = {{(NWORDS-1){1'b0}}, 1'b1} << w_off;
    assign w_dup        = |(w_mask & w_off_onehot);

    // Only a fresh word during a fill is stored; everything else is dropped.
    assign w_rd_ok      = w_is_read & (r_state == FILL) & ~w_dup;
    assign w_err_beat   = w_fire & (~w_fmt_ok | (w_is_read & ((r_state == IDLE) | w_dup)));
    assign w_mask_after = w_mask | w_off_onehot;
    assign w_completes  = w_rd_ok & (&w_mask_after);
    assign w_crit_hit   = w_rd_ok & (w_off == r_crit_off);

    assign w_start      = start_val & (r_state == IDLE);
    assign w_handoff    = line_rdy & (r_state == FULL);
    assign w_clr        = w_start | w_handoff;

    lab3_cache_word_slot_bank #(
        .NWORDS    (NWORDS),
        .WORD_BITS (WORD_BITS),
        .OFF_BITS  (OFF_BITS)
    ) u_slots (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_rd_ok),
        .i_widx  (w_off),
        .i_wdata (w_resp.data),
        .i_clr   (w_clr),
        .o_mask  (w_mask),
        .o_line  (line_data)
    );

    // Refill FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_start_rdy <= 1'b1;
            r_resp_rdy  <= 1'b1;
            r_line_val  <= 1'b0;
            r_crit_off  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= FILL;
                        r_start_rdy <= 1'b0;
                        r_crit_off  <= start_crit_off;
                    end else begin
                        r_state     <= IDLE;
                    end
                end
                FILL: begin
                    if (w_completes) begin
                        r_state    <= FULL;
                        r_line_val <= 1'b1;
                        r_resp_rdy <= 1'b0;
                    end else begin
                        r_state    <= FILL;
                    end
                end
                FULL: begin
                    if (line_rdy) begin
                        r_state     <= IDLE;
                        r_line_val  <= 1'b0;
                        r_resp_rdy  <= 1'b1;
                        r_start_rdy <= 1'b1;
                    end else begin
                        r_state     <= FULL;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_start_rdy <= 1'b1;
                    r_resp_rdy  <= 1'b1;
                    r_line_val  <= 1'b0;
                end
            endcase
        end
    end

    // Critical word pulse; the data stays until another critical word lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crit_val  <= 1'b0;
            r_crit_data <= '0;
        end else if (w_crit_hit) begin
            r_crit_val  <= 1'b1;
            r_crit_data <= w_resp.data;
        end else begin
            r_crit_val  <= 1'b0;
        end
    end

    // Writeback ack counter: wraps on the 16th ack and pulses wb_done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_cnt  <= 5'd0;
            r_wb_done <= 1'b0;
        end else if (w_is_ack) begin
            r_wb_cnt  <= (r_wb_cnt == WB_LAST) ? 5'd0 : (r_wb_cnt + 5'd1);
            r_wb_done <= (r_wb_cnt == WB_LAST);
        end else begin
            r_wb_done <= 1'b0;
        end
    end

    // Sticky protocol error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err | w_err_beat;
        end
    end

    assign start_rdy = r_start_rdy;
    assign resp_rdy  = r_resp_rdy;
    assign line_val  = r_line_val;
    assign crit_val  = r_crit_val;
    assign crit_data = r_crit_data;
    assign wb_done   = r_wb_done;
    assign err       = r_err;

endmodule

// File: tb/tb_lab3_cache_refill_collector.sv
// Self-checking bench for lab3_cache_refill_collector: directed refill
// scenarios plus a randomized phase, all checked every cycle against a
// behavioural line-refill model.
module tb_lab3_cache_refill_collector;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_val;
    logic         start_rdy;
    logic [3:0]   start_crit_off;
    logic         resp_val;
    logic         resp_rdy;
    logic [46:0]  resp_msg;
    logic         line_val;
    logic         line_rdy;
    logic [511:0] line_data;
    logic         crit_val;
    logic [31:0]  crit_data;
    logic         wb_done;
    logic         err;

    always #5 clk = ~clk;

    lab3_cache_refill_collector dut (
        .clk            (clk),
        .reset          (reset),
        .start_val      (start_val),
        .start_rdy      (start_rdy),
        .start_crit_off (start_crit_off),
        .resp_val       (resp_val),
        .resp_rdy       (resp_rdy),
        .resp_msg       (resp_msg),
        .line_val       (line_val),
        .line_rdy       (line_rdy),
        .line_data      (line_data),
        .crit_val       (crit_val),
        .crit_data      (crit_data),
        .wb_done        (wb_done),
        .err            (err)
    );

    int n_vec     = 0;
    int n_miss    = 0;
    int n_wb_seen = 0;
    bit chk_en    = 1'b0;

    // Behavioural model: a refill is "open" from its start until the line is
    // handed off; the line is ready once every word has been received.
    bit          m_open;
    bit          m_have [16];
    logic [31:0] m_word [16];
    logic [3:0]  m_crit_off;
    bit          m_crit_pulse;
    logic [31:0] m_crit_data;
    int          m_acks;
    bit          m_wb_pulse;
    bit          m_err;

    function automatic bit m_complete();
        for (int i = 0; i < 16; i++) begin
            if (!m_have[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [511:0] m_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = m_word[i];
        return l;
    endfunction

    task automatic model_reset();
        m_open = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_have[i] = 1'b0;
            m_word[i] = 32'd0;
        end
        m_crit_off   = 4'd0;
        m_crit_pulse = 1'b0;
        m_crit_data  = 32'd0;
        m_acks       = 0;
        m_wb_pulse   = 1'b0;
        m_err        = 1'b0;
    endtask

    task automatic model_step(input bit sv, input logic [3:0] co, input bit rv,
                              input logic [46:0] msg, input bit lr);
        bit          was_open = m_open;
        bit          was_full = m_open && m_complete();
        logic [2:0]  t  = msg[46:44];
        logic [3:0]  op = msg[39:36];
        logic [1:0]  ln = msg[33:32];
        logic [31:0] d  = msg[31:0];
        m_crit_pulse = 1'b0;
        m_wb_pulse   = 1'b0;
        if (rv && !was_full) begin
            if (t > 3'd1 || ln != 2'd0) begin
                m_err = 1'b1;
            end else if (t == 3'd1) begin
                m_acks++;
                if (m_acks == 16) begin
                    m_acks     = 0;
                    m_wb_pulse = 1'b1;
                end
            end else if (!was_open || m_have[op]) begin
                m_err = 1'b1;
            end else begin
                m_have[op] = 1'b1;
                m_word[op] = d;
                if (op == m_crit_off) begin
                    m_crit_pulse = 1'b1;
                    m_crit_data  = d;
                end
            end
        end
        if (!was_open && sv) begin
            m_open     = 1'b1;
            m_crit_off = co;
            for (int i = 0; i < 16; i++) m_have[i] = 1'b0;
        end else if (was_full && lr) begin
            m_open = 1'b0;
            for (int i = 0; i < 16; i++) m_have[i] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            if (wb_done === 1'b1) n_wb_seen++;
            chk("cyc_start_rdy", start_rdy, !m_open);
            chk("cyc_resp_rdy",  resp_rdy,  !(m_open && m_complete()));
            chk("cyc_line_val",  line_val,  m_open && m_complete());
            chk("cyc_line_data", line_data, m_line());
            chk("cyc_crit_val",  crit_val,  m_crit_pulse);
            chk("cyc_crit_data", crit_data, m_crit_data);
            chk("cyc_wb_done",   wb_done,   m_wb_pulse);
            chk("cyc_err",       err,       m_err);
        end
    end

    function automatic logic [46:0] mk(input logic [2:0] t, input logic [7:0] op,
                                       input logic [1:0] ln, input logic [31:0] d);
        return {t, op, 2'($urandom_range(0, 3)), ln, d};
    endfunction

    function automatic logic [46:0] rd(input logic [7:0] op, input logic [31:0] d);
        return mk(3'd0, op, 2'd0, d);
    endfunction

    function automatic logic [46:0] ack();
        return mk(3'd1, 8'($urandom_range(0, 255)), 2'd0, 32'($urandom));
    endfunction

    // Drive one cycle's inputs, advance the model, land at negedge+1.
    task automatic cycle(input bit sv, input logic [3:0] co, input bit rv,
                         input logic [46:0] msg, input bit lr);
        start_val      = sv;
        start_crit_off = co;
        resp_val       = rv;
        resp_msg       = msg;
        line_rdy       = lr;
        model_step(sv, co, rv, msg, lr);
        n_vec++;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        start_val      = 1'b0;
        resp_val       = 1'b0;
        line_rdy       = 1'b0;
        resp_msg       = '0;
        start_crit_off = 4'd0;
        model_reset();
        #1;
        chk("rst_now_line_val", line_val, 1'b0);
        chk("rst_now_start_rdy", start_rdy, 1'b1);
        chk("rst_now_err", err, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    int perm [16];

    task automatic make_perm();
        int j, tmp;
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
    endtask

    // Start a refill and deliver 16 random-data words in random order.
    task automatic fill_random(input logic [3:0] co);
        logic [31:0] sent [16];
        make_perm();
        cycle(1'b1, co, 1'b0, '0, 1'b0);
        chk("fill_start_taken", start_rdy, 1'b0);
        for (int k = 0; k < 16; k++) begin
            sent[perm[k]] = 32'($urandom);
            cycle(1'b0, 4'd0, 1'b1, rd(8'(perm[k]), sent[perm[k]]), 1'b0);
        end
        chk("fill_line_val", line_val, 1'b1);
        for (int i = 0; i < 16; i++) chk("fill_word", line_data[i*32 +: 32], sent[i]);
    endtask

    initial begin
        logic [46:0] msg;
        bit          ev_read [32];
        int          nr, j;
        bit          tb;

        reset = 1'b0; start_val = 1'b0; resp_val = 1'b0; line_rdy = 1'b0;
        resp_msg = '0; start_crit_off = 4'd0;
        model_reset();
        chk_en = 1'b1;
        @(negedge clk); #1;
        chk("reset_start_rdy", start_rdy, 1'b1);
        chk("reset_resp_rdy",  resp_rdy,  1'b1);
        chk("reset_line_val",  line_val,  1'b0);
        chk("reset_line_data", line_data, 512'd0);
        chk("reset_crit_data", crit_data, 32'd0);
        chk("reset_err",       err,       1'b0);
        @(negedge clk); #1;
        reset = 1'b1;

        // In-order fill, critical word 0.
        cycle(1'b1, 4'd0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 4'd0, 1'b1, rd(8'(i), 32'h100 + 32'(i)), 1'b0);
            if (i == 0) begin
                chk("inorder_crit_val", crit_val, 1'b1);
                chk("inorder_crit_data", crit_data, 32'h100);
            end
            if (i < 15) chk("inorder_not_full", line_val, 1'b0);
        end
        chk("inorder_line_val", line_val, 1'b1);
        for (int i = 0; i < 16; i++) chk("inorder_word", line_data[i*32 +: 32], 32'h100 + 32'(i));
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        chk("inorder_back_idle", start_rdy, 1'b1);

        // Reverse-order fill, critical word 5, line held for three cycles.
        cycle(1'b1, 4'd5, 1'b0, '0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            cycle(1'b0, 4'd0, 1'b1, rd(8'(15 - k), 32'h100 + 32'(15 - k)), 1'b0);
            chk("rev_crit_once", crit_val, (15 - k) == 5);
        end
        chk("rev_crit_data", crit_data, 32'h105);
        for (int h = 0; h < 3; h++) begin
            cycle(1'b0, 4'd0, 1'b1, rd(8'd2, 32'hBAD), 1'b0);
            chk("rev_hold_line_val", line_val, 1'b1);
            chk("rev_hold_resp_rdy", resp_rdy, 1'b0);
        end
        chk("rev_word0", line_data[31:0], 32'h100);
        chk("rev_word15", line_data[511:480], 32'h10F);
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        chk("rev_start_rdy", start_rdy, 1'b1);

        // Writeback drain interleaved with a fill; a read is the last event.
        n_wb_seen = 0;
        make_perm();
        for (int i = 0; i < 32; i++) ev_read[i] = (i < 15) || (i == 31);
        for (int i = 30; i > 0; i--) begin
            j = $urandom_range(0, i);
            tb = ev_read[i]; ev_read[i] = ev_read[j]; ev_read[j] = tb;
        end
        cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, '0, 1'b0);
        nr = 0;
        for (int i = 0; i < 32; i++) begin
            if (ev_read[i]) begin
                cycle(1'b0, 4'd0, 1'b1, rd(8'(perm[nr]), 32'($urandom)), 1'b0);
                nr++;
            end else begin
                cycle(1'b0, 4'd0, 1'b1, ack(), 1'b0);
            end
        end
        chk("wb_one_pulse", n_wb_seen, 1);
        chk("wb_line_val", line_val, 1'b1);
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b0, 4'd0, 1'b1, ack(), 1'b0);
        chk("wb_wrapped_15", n_wb_seen, 1);
        cycle(1'b0, 4'd0, 1'b1, ack(), 1'b0);
        chk("wb_wrapped_16", n_wb_seen, 2);

        // Duplicate word, then a read with no refill open.
        chk("err_clean", err, 1'b0);
        cycle(1'b1, 4'd2, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 1'b1, rd(8'(i), 32'h200 + 32'(i)), 1'b0);
        cycle(1'b0, 4'd0, 1'b1, rd(8'd3, 32'hDEAD0003), 1'b0);
        chk("err_dup_set", err, 1'b1);
        for (int i = 4; i < 15; i++) cycle(1'b0, 4'd0, 1'b1, rd(8'(i), 32'h200 + 32'(i)), 1'b0);
        chk("err_needs_last", line_val, 1'b0);
        cycle(1'b0, 4'd0, 1'b1, rd(8'd15, 32'h20F), 1'b0);
        chk("err_line_val", line_val, 1'b1);
        chk("err_word3_kept", line_data[127:96], 32'h203);
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        cycle(1'b0, 4'd0, 1'b1, rd(8'd7, 32'h7777), 1'b0);
        chk("err_sticky", err, 1'b1);

        // Reset after seven beats, then a clean fill.
        cycle(1'b1, 4'd9, 1'b0, '0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 4'd0, 1'b1, rd(8'(i), 32'h300 + 32'(i)), 1'b0);
        do_reset();
        fill_random(4'($urandom_range(0, 15)));
        chk("rst_fill_err", err, 1'b0);

        // Back-to-back refills: start the cycle after the handoff.
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);
        fill_random(4'($urandom_range(0, 15)));
        cycle(1'b0, 4'd0, 1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            nr = $urandom_range(0, 19);
            if (nr < 13)      msg = rd(8'($urandom_range(0, 255)), 32'($urandom));
            else if (nr < 17) msg = ack();
            else if (nr < 19) msg = mk(3'($urandom_range(2, 7)), 8'($urandom_range(0, 255)), 2'd0, 32'($urandom));
            else              msg = mk(3'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3)), 32'($urandom));
            if (c == 1200) do_reset();
            cycle($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 9) < 7, msg, $urandom_range(0, 3) == 0);
        end

        cycle(1'b0, 4'd0, 1'b0, '0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
